// File: rtl/m_dram_arb2.sv
// Two-hart DRAM arbiter: latches per-hart load/store pulses, serialises them onto one DRAM port.
// Optional macro DRAM_ARB_FIXED_PRIO_EN: hart 0 always wins ties instead of round-robin.
module m_dram_arb2 #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int RISE_WAIT = 4
) (
    input  logic              CLK,
    input  logic              RST_X,
    input  logic [ADDR_W-1:0] w_c0_addr,
    input  logic [ADDR_W-1:0] w_c1_addr,
    input  logic [DATA_W-1:0] w_c0_wdata,
    input  logic [DATA_W-1:0] w_c1_wdata,
    input  logic [2:0]        w_c0_ctrl,
    input  logic [2:0]        w_c1_ctrl,
    input  logic              w_c0_le,
    input  logic              w_c1_le,
    input  logic              w_c0_we_t,
    input  logic              w_c1_we_t,
    output logic [DATA_W-1:0] w_c0_odata,
    output logic [DATA_W-1:0] w_c1_odata,
    output logic              w_c0_busy,
    output logic              w_c1_busy,
    output logic [ADDR_W-1:0] w_dram_addr,
    output logic [DATA_W-1:0] w_dram_wdata,
    output logic [2:0]        w_dram_ctrl,
    output logic              w_dram_le,
    output logic              w_dram_we_t,
    input  logic [DATA_W-1:0] w_dram_odata,
    input  logic              w_dram_busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_RISE,
        S_FALL,
        S_DONE
    } state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [2:0]        ctrl;
        logic              is_store;
    } req_t;

    localparam logic [3:0] RISE_LIMIT = 4'(RISE_WAIT);

    state_t            state;
    req_t              in_req  [2];
    req_t              lat     [2];
    logic [DATA_W-1:0] odata   [2];
    logic [1:0]        in_pulse;
    logic [1:0]        pending;
    logic              grant;
    logic              grant_next;
    logic [3:0]        rise_cnt;
    logic [3:0]        rise_inc;

`ifndef DRAM_ARB_FIXED_PRIO_EN
    logic              last_grant;
`endif

    // A simultaneous le/we_t pair is recorded as a store.
    always_comb begin
        in_req[0] = '{addr: w_c0_addr, wdata: w_c0_wdata, ctrl: w_c0_ctrl, is_store: w_c0_we_t};
        in_req[1] = '{addr: w_c1_addr, wdata: w_c1_wdata, ctrl: w_c1_ctrl, is_store: w_c1_we_t};
    end

    assign in_pulse = {w_c1_le | w_c1_we_t, w_c0_le | w_c0_we_t};
    assign rise_inc = rise_cnt + 4'd1;

    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        grant_next = 1'b0;
        if (pending == 2'b10) begin
            grant_next = 1'b1;
        end else if (pending == 2'b11) begin
`ifdef DRAM_ARB_FIXED_PRIO_EN
            grant_next = 1'b0;
`else
            grant_next = ~last_grant;
`endif
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    // NOTE: the request latches are reset too; they are a few flops, not a RAM, and a clean bus after reset is worth it.
    always_ff @(posedge CLK or negedge RST_X) begin
        if (!RST_X) begin
            state        <= S_IDLE;
            pending      <= 2'b00;
            grant        <= 1'b0;
`ifndef DRAM_ARB_FIXED_PRIO_EN
            last_grant   <= 1'b1;
`endif
            rise_cnt     <= 4'd0;
            w_dram_addr  <= '0;
            w_dram_wdata <= '0;
            w_dram_ctrl  <= 3'd0;
            w_dram_le    <= 1'b0;
            w_dram_we_t  <= 1'b0;
            for (int h = 0; h < 2; h++) begin
                lat[h]   <= '0;
                odata[h] <= '0;
            end
        end else begin
            for (int h = 0; h < 2; h++) begin
                if (in_pulse[h] && !pending[h]) begin
                    lat[h]     <= in_req[h];
                    pending[h] <= 1'b1;
                end
            end

            case (state)
                S_IDLE: begin
                    if (!w_dram_busy && (pending != 2'b00)) begin
                        grant        <= grant_next;
`ifndef DRAM_ARB_FIXED_PRIO_EN
                        last_grant   <= grant_next;
`endif
                        w_dram_addr  <= lat[grant_next].addr;
                        w_dram_wdata <= lat[grant_next].wdata;
                        w_dram_ctrl  <= lat[grant_next].ctrl;
                        w_dram_we_t  <= lat[grant_next].is_store;
                        w_dram_le    <= !lat[grant_next].is_store;
                        state        <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    w_dram_le   <= 1'b0;
                    w_dram_we_t <= 1'b0;
                    rise_cnt    <= 4'd0;
                    state       <= S_RISE;
                end
                S_RISE: begin
                    // A controller that never acknowledges must not wedge the arbiter.
                    if (w_dram_busy) begin
                        state <= S_FALL;
                    end else begin
                        rise_cnt <= rise_inc;
                        if (rise_inc == RISE_LIMIT) begin
                            state <= S_DONE;
                        end
                    end
                end
                S_FALL: begin
                    if (!w_dram_busy) begin
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (!lat[grant].is_store) begin
                        odata[grant] <= w_dram_odata;
                    end
                    pending[grant] <= 1'b0;
                    state          <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign w_c0_odata = odata[0];
    assign w_c1_odata = odata[1];
    assign w_c0_busy  = pending[0];
    assign w_c1_busy  = pending[1];

endmodule
